// File: rtl/uart_tx.sv
// uart_tx: 8N1, LSB-first UART transmitter fed by a small elastic FIFO.
// Bytes enter through a valid/ready handshake, are queued, and are serialised
// at XCLK/BAUD_DIV. Frames sent back to back are contiguous on the line.
module uart_tx #(
    parameter int unsigned BAUD_DIV  = 868,
    parameter int unsigned FIFO_LOG2 = 2
) (
    input  logic                 XCLK,
    input  logic                 XRES,
    input  logic [7:0]           TX_DATA,
    input  logic                 TX_VALID,
    output logic                 TX_READY,
    output logic                 UART_TXD,
    output logic                 TX_BUSY,
    output logic [FIFO_LOG2:0]   FIFO_COUNT
);

    localparam int unsigned        DEPTH       = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] FULL_COUNT  = (FIFO_LOG2 + 1)'(DEPTH);
    localparam logic [15:0]        BAUD_RELOAD = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]           fifoMem [DEPTH];
    logic [FIFO_LOG2-1:0] wrPtr_q;
    logic [FIFO_LOG2-1:0] rdPtr_q;
    logic [FIFO_LOG2:0]   count_q;
    logic [FIFO_LOG2:0]   count_d;
    logic                 push;
    logic                 pop;
    logic                 fifoEmpty;

    // Serialiser state
    state_t      state_q;
    state_t      state_d;
    logic [15:0] baudCnt_q;
    logic [15:0] baudCnt_d;
    logic [2:0]  bitIdx_q;
    logic [2:0]  bitIdx_d;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic        txd_q;
    logic        txd_d;
    logic        baudZero;

    // Ready is decoded from the registered count only, so TX_VALID never
    // reaches TX_READY combinationally.
    assign TX_READY   = (count_q != FULL_COUNT);
    assign push       = TX_VALID && TX_READY;
    assign fifoEmpty  = (count_q == '0);
    assign baudZero   = (baudCnt_q == '0);
    assign FIFO_COUNT = count_q;
    assign TX_BUSY    = (state_q != IDLE) || (count_q != '0);
    assign UART_TXD   = txd_q;

    // Occupancy follows push/pop; a simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO pointers and count; reset discards anything still queued.
    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // FIFO storage is written only on accepted pushes, so TX_DATA is ignored otherwise.
    always_ff @(posedge XCLK) begin
        if (push) begin
            fifoMem[wrPtr_q] <= TX_DATA;
        end
    end

    // State register for the serialiser, including the registered line output.
    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

    // Next-state logic: the baud counter paces every bit, and STOP chains
    // directly into the next START when another byte is waiting.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    shift_d   = fifoMem[rdPtr_q];
                    baudCnt_d = BAUD_RELOAD;
                    state_d   = START;
                end
            end
            START: begin
                if (baudZero) begin
                    baudCnt_d = BAUD_RELOAD;
                    bitIdx_d  = '0;
                    state_d   = DATA;
                end else begin
                    baudCnt_d = baudCnt_q - 1'b1;
                end
            end
            DATA: begin
                if (baudZero) begin
                    baudCnt_d = BAUD_RELOAD;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 1'b1;
                    end
                end else begin
                    baudCnt_d = baudCnt_q - 1'b1;
                end
            end
            STOP: begin
                if (baudZero) begin
                    if (!fifoEmpty) begin
                        pop       = 1'b1;
                        shift_d   = fifoMem[rdPtr_q];
                        baudCnt_d = BAUD_RELOAD;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baudCnt_d = baudCnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: line level for the upcoming state, so UART_TXD is glitch-free.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[bitIdx_d];
            default: txd_d = 1'b1;
        endcase
    end

endmodule
